sipo_frame_ctrl: RTL and testbench
==================================

Name: sipo_frame_ctrl

Overview:
- Controller that sequences a serial-in/parallel-out shift register to receive framed serial words.
- Frame format: start bit, data bits, optional even-parity bit, stop bit.
- Detects the start bit, counts exactly DATA_W data bits into the shift register, checks parity and stop, then presents the word on a valid/ready output port.
- Sits between a serial line (sampled on a bit-enable strobe) and the parallel consumer.

Parameters:
- DATA_W, 4: number of data bits per frame; also the width of the parallel output.
- PARITY_EN, 1: 1 = frame carries an even-parity bit after the data bits; 0 = no parity bit.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- bit_en  input  1  bit-sample strobe; si is sampled only on cycles where bit_en=1.
- si  input  1  serial input; idle level is 1.
- po  output  DATA_W  received parallel word; the first data bit received ends up in po[DATA_W-1].
- po_valid  output  1  po holds an unconsumed word.
- po_ready  input  1  consumer accepts po when po_valid and po_ready are both 1.
- busy  output  1  1 while in any state other than IDLE.
- parity_err  output  1  one-cycle pulse when a frame fails the parity check.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- overrun  output  1  one-cycle pulse when a good frame completes while an old word is still unconsumed.

Behaviour:
- Reset (rst=1 at a clock edge, from any state):
  - state=IDLE; shift register, bit counter and parity accumulator cleared.
  - po=0, po_valid=0, busy=0, parity_err=0, frame_err=0, overrun=0.
  - A frame in progress is abandoned.
- State machine. All transitions except the po_valid/output logic occur only on cycles with bit_en=1.
  - IDLE: si=0 -> SHIFT; clear bit counter and parity accumulator. si=1 -> stay in IDLE.
  - SHIFT: shift register <= {shift[DATA_W-2:0], si}; parity accumulator ^= si; counter++.
    - After the DATA_W-th bit: go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - PARITY: parity accumulator ^= si, then go to STOP. A nonzero accumulator (odd total of ones) marks the frame bad.
  - STOP, si=1, parity good: frame complete. Next edge: po <= shift register, po_valid <= 1. Go to IDLE.
  - STOP, si=0: frame_err pulses on the next cycle. Frame discarded; po and po_valid unchanged. Go to IDLE.
  - STOP, si=1, parity bad: parity_err pulses on the next cycle. Frame discarded. Go to IDLE.
- Timing:
  - Latency: po_valid rises on the edge that samples the stop bit.
  - Total frame length is DATA_W+2+PARITY_EN bit_en strobes.
  - IDLE may accept a new start bit on the very next bit_en after STOP (back-to-back frames).
- Handshake rules:
  - po_valid=1 and po_ready=1 at an edge with no completion: po_valid <= 0.
  - po and po_valid are stable while po_valid=1 and po_ready=0.
  - Completion with po_valid=1 and po_ready=0: new word dropped, old po kept, overrun pulses for one cycle.
  - Completion with po_valid=1 and po_ready=1 in the same cycle: new word loaded, po_valid stays 1, no overrun.
  - po_ready is ignored while po_valid=0.
- Misc:
  - bit_en=0 holds state, counter and shift register. The handshake still operates.
  - The three error pulses are mutually exclusive. Each lasts exactly one clk cycle, regardless of bit_en.
  - busy is combinational from state.

Test Plan:
- Reset mid-frame: assert rst after 2 data bits -> next cycle busy=0, po=0, po_valid=0. A following full frame is received correctly.
- Good frame (DATA_W=4, PARITY_EN=1, bit_en every cycle): si=0,1,0,1,1,1,1 (start, data 1011, parity 1, stop) -> po=4'b1011, po_valid=1 on the stop-sample edge. po_ready=1 one cycle later -> po_valid=0.
- Parity/framing errors: data 1011, parity 0 -> parity_err one pulse, po_valid stays 0. Data 0110, parity 0, stop 0 -> frame_err one pulse, po unchanged.
- Overrun and simultaneous accept:
  - Receive 4'b1011 and hold po_ready=0; receive 4'b0110 -> overrun pulse, po stays 4'b1011.
  - Repeat with po_ready=1 on the completion cycle -> po=4'b0110, po_valid=1, no overrun.
- bit_en throttling: bit_en high every 4th cycle, frame 0,1,1,0,0,0,1 -> po=4'b1100. No state change on bit_en=0 cycles. busy spans exactly 7 strobes.
- Back-to-back with PARITY_EN=0: frames with data 4'b1001 and 4'b0011 sent with no idle bits, po_ready=1 -> two completions, po=4'b1001 then 4'b0011, no errors.

Source files
------------

// File: rtl/sipo_frame_ctrl_if.sv
// sipo_frame_ctrl_if: serial line, parallel valid/ready port and error pulses of the SIPO frame receiver.
interface sipo_frame_ctrl_if #(parameter int DATA_W = 4);
    logic              bit_en;
    logic              si;
    logic [DATA_W-1:0] po;
    logic              po_valid;
    logic              po_ready;
    logic              busy;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;

    modport slave (
        input  bit_en, si, po_ready,
        output po, po_valid, busy, parity_err, frame_err, overrun
    );

    modport master (
        output bit_en, si, po_ready,
        input  po, po_valid, busy, parity_err, frame_err, overrun
    );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: receives start/data/[even parity]/stop frames into a shift register and offers each good word on a valid/ready port.
module sipo_frame_ctrl #(
    parameter int DATA_W    = 4,
    parameter bit PARITY_EN = 1
) (
    input logic             clk,
    input logic             rst,
    sipo_frame_ctrl_if.slave bus
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_shift, r_po;
    logic [CW-1:0]     r_cnt;
    logic              r_par, r_valid, r_perr, r_ferr, r_ovr;
    logic              w_stop, w_bad, w_done;

    assign w_stop = bus.bit_en && r_state == STOP;
    // without a parity bit the accumulator only sees data, so it must not judge the frame
    assign w_bad  = PARITY_EN && r_par;
    assign w_done = w_stop && bus.si && !w_bad;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.bit_en)
            w_next = r_state == IDLE   ? (bus.si ? IDLE : SHIFT) :
                     r_state == SHIFT  ? (r_cnt == CW'(DATA_W - 1) ? (PARITY_EN ? PARITY : STOP) : SHIFT) :
                     r_state == PARITY ? STOP : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_po    <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (bus.bit_en && r_state == IDLE && !bus.si) begin
                r_cnt <= '0;
                r_par <= 1'b0;
            end
            if (bus.bit_en && r_state == SHIFT) begin
                r_shift <= {r_shift[DATA_W-2:0], bus.si};
                r_par   <= r_par ^ bus.si;
                r_cnt   <= r_cnt + 1'b1;
            end
            if (bus.bit_en && r_state == PARITY) r_par <= r_par ^ bus.si;
            r_perr <= w_stop && bus.si && w_bad;
            r_ferr <= w_stop && !bus.si;
            r_ovr  <= w_done && r_valid && !bus.po_ready;
            // a completion may replace the word only if the old one is gone or leaving this cycle
            if (w_done && (!r_valid || bus.po_ready)) begin
                r_po    <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && bus.po_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.po         = r_po;
    assign bus.po_valid   = r_valid;
    assign bus.busy       = r_state != IDLE;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.overrun    = r_ovr;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: directed and random frames into a parity and a no-parity receiver, checked against a frame-level model.
module tb_sipo_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt;
    logic [3:0] ep_po, en_po;
    logic       ep_v, en_v;

    always #5 clk = ~clk;

    sipo_frame_ctrl_if #(.DATA_W(4)) p_if ();
    sipo_frame_ctrl_if #(.DATA_W(4)) n_if ();

    sipo_frame_ctrl #(.DATA_W(4), .PARITY_EN(1)) dut_p (.clk(clk), .rst(rst), .bus(p_if.slave));
    sipo_frame_ctrl #(.DATA_W(4), .PARITY_EN(0)) dut_n (.clk(clk), .rst(rst), .bus(n_if.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // outcome of sampling the stop bit, from the frame contents and the consumer's state
    task automatic model(input logic [3:0] d, input logic bad, input logic s, input logic rdy,
                         input logic [3:0] po_i, input logic v_i,
                         output logic [3:0] po_o, output logic v_o,
                         output logic pe, output logic fe, output logic ov);
        fe   = !s;
        pe   = s && bad;
        ov   = s && !bad && v_i && !rdy;
        po_o = po_i;
        v_o  = v_i;
        if (s && !bad && (!v_i || rdy)) begin
            po_o = d;
            v_o  = 1'b1;
        end else if (v_i && rdy) begin
            v_o = 1'b0;
        end
    endtask

    task automatic p_bit(input logic b, input int gap);
        p_if.si = b;
        p_if.bit_en = 1'b1;
        tick;
        busy_cnt += int'(p_if.busy);
        p_if.bit_en = 1'b0;
        p_if.si = 1'b1;
        repeat (gap) begin
            tick;
            busy_cnt += int'(p_if.busy);
            chk("p_hold_valid", int'(p_if.po_valid), int'(ep_v));
        end
    endtask

    task automatic p_frame(input logic [3:0] d, input logic par, input logic s, input logic rdy, input int gap);
        logic [3:0] npo;
        logic nv, pe, fe, ov;
        busy_cnt = 0;
        p_bit(1'b0, gap);
        for (int i = 3; i >= 0; i--) p_bit(d[i], gap);
        p_bit(par, gap);
        p_if.si = s;
        p_if.bit_en = 1'b1;
        p_if.po_ready = rdy;
        tick;
        p_if.si = 1'b1;
        p_if.bit_en = 1'b0;
        p_if.po_ready = 1'b0;
        model(d, ^d ^ par, s, rdy, ep_po, ep_v, npo, nv, pe, fe, ov);
        ep_po = npo;
        ep_v  = nv;
        chk("p_po", int'(p_if.po), int'(ep_po));
        chk("p_po_valid", int'(p_if.po_valid), int'(ep_v));
        chk("p_parity_err", int'(p_if.parity_err), int'(pe));
        chk("p_frame_err", int'(p_if.frame_err), int'(fe));
        chk("p_overrun", int'(p_if.overrun), int'(ov));
        chk("p_busy_end", int'(p_if.busy), 0);
        tick;
        chk("p_pulse_len", int'({p_if.parity_err, p_if.frame_err, p_if.overrun}), 0);
    endtask

    task automatic p_consume;
        p_if.po_ready = 1'b1;
        tick;
        p_if.po_ready = 1'b0;
        ep_v = 1'b0;
        chk("p_consume_valid", int'(p_if.po_valid), 0);
        chk("p_consume_po", int'(p_if.po), int'(ep_po));
    endtask

    task automatic n_bit(input logic b);
        if (en_v && n_if.po_ready) en_v = 1'b0;
        n_if.si = b;
        n_if.bit_en = 1'b1;
        tick;
        chk("n_valid", int'(n_if.po_valid), int'(en_v));
    endtask

    task automatic n_frame(input logic [3:0] d, input logic s);
        logic [3:0] npo;
        logic nv, pe, fe, ov;
        n_bit(1'b0);
        chk("n_busy_start", int'(n_if.busy), 1);
        for (int i = 3; i >= 0; i--) n_bit(d[i]);
        n_if.si = s;
        n_if.bit_en = 1'b1;
        model(d, 1'b0, s, n_if.po_ready, en_po, en_v, npo, nv, pe, fe, ov);
        tick;
        en_po = npo;
        en_v  = nv;
        chk("n_po", int'(n_if.po), int'(en_po));
        chk("n_po_valid", int'(n_if.po_valid), int'(en_v));
        chk("n_errs", int'({n_if.parity_err, n_if.frame_err, n_if.overrun}), int'({pe, fe, ov}));
        chk("n_busy_end", int'(n_if.busy), 0);
    endtask

    initial begin
        logic [3:0] d;
        logic       par, s, rdy;
        p_if.bit_en = 1'b0; p_if.si = 1'b1; p_if.po_ready = 1'b0;
        n_if.bit_en = 1'b0; n_if.si = 1'b1; n_if.po_ready = 1'b0;
        ep_po = '0; ep_v = 1'b0; en_po = '0; en_v = 1'b0;
        tick;
        tick;
        chk("rst_po", int'(p_if.po), 0);
        chk("rst_flags", int'({p_if.po_valid, p_if.busy, p_if.parity_err, p_if.frame_err, p_if.overrun}), 0);
        rst = 1'b0;

        p_frame(4'b1011, 1'b1, 1'b1, 1'b0, 0);
        p_consume;

        p_bit(1'b0, 0);
        p_bit(1'b1, 0);
        p_bit(1'b0, 0);
        chk("mid_busy", int'(p_if.busy), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ep_po = '0;
        ep_v  = 1'b0;
        chk("midrst_busy", int'(p_if.busy), 0);
        chk("midrst_po", int'(p_if.po), 0);
        chk("midrst_valid", int'(p_if.po_valid), 0);
        p_frame(4'b1100, 1'b0, 1'b1, 1'b0, 0);
        p_consume;

        p_frame(4'b1011, 1'b0, 1'b1, 1'b0, 0);
        p_frame(4'b0110, 1'b0, 1'b0, 1'b0, 0);

        p_frame(4'b1011, 1'b1, 1'b1, 1'b0, 0);
        p_frame(4'b0110, 1'b0, 1'b1, 1'b0, 0);
        p_frame(4'b0110, 1'b0, 1'b1, 1'b1, 0);
        p_consume;

        p_frame(4'b1100, 1'b0, 1'b1, 1'b0, 3);
        chk("throttle_busy", busy_cnt, 24);
        p_consume;

        repeat (40) begin
            d   = 4'($urandom);
            par = ^d ^ ($urandom_range(0, 3) == 0);
            s   = $urandom_range(0, 5) != 0;
            rdy = 1'($urandom);
            p_frame(d, par, s, rdy, $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) p_consume;
        end

        n_if.po_ready = 1'b1;
        n_frame(4'b1001, 1'b1);
        n_frame(4'b0011, 1'b1);
        n_if.bit_en = 1'b0;
        n_if.si = 1'b1;
        if (en_v) en_v = 1'b0;
        tick;
        chk("n_b2b_valid", int'(n_if.po_valid), int'(en_v));
        chk("n_b2b_pulses", int'({n_if.parity_err, n_if.frame_err, n_if.overrun}), 0);

        repeat (12) begin
            n_if.po_ready = 1'($urandom);
            n_frame(4'($urandom), $urandom_range(0, 4) != 0);
        end
        n_if.bit_en = 1'b0;
        n_if.si = 1'b1;
        tick;
        chk("n_tail_pulses", int'({n_if.parity_err, n_if.frame_err, n_if.overrun}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
